// File: rtl/fetch_queue_pkg.sv
// Shared opcode/func constants, predecode class encodings and the stored entry layout
// for the fetch queue.
package fetch_queue_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] FUNC_JR    = 6'b001000;

  localparam logic [1:0] CTRL_SEQ = 2'b00;
  localparam logic [1:0] CTRL_BR  = 2'b01;
  localparam logic [1:0] CTRL_J   = 2'b10;
  localparam logic [1:0] CTRL_JR  = 2'b11;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [1:0]  ctrl;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue_predecode.sv
// Combinational control-flow classifier: maps an instruction word to its 2-bit
// predecode class (seq, beq, j/jal, jr).
module fetchq_predecode
  import fetch_queue_pkg::*;
(
  input  logic [31:0] instr,
  output logic [1:0]  ctrl
);

  logic [5:0] op;
  logic [5:0] func;

  assign op   = instr[31:26];
  assign func = instr[5:0];

  always_comb begin
    ctrl = CTRL_SEQ;
    if (op == OP_BEQ) begin
      ctrl = CTRL_BR;
    end else if (op == OP_J || op == OP_JAL) begin
      ctrl = CTRL_J;
    end else if (op == OP_SPECIAL && func == FUNC_JR) begin
      ctrl = CTRL_JR;
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction buffer with flush and predecode on entry.
// Optional FETCHQ_BYPASS_EN lets an empty queue forward the incoming word combinationally.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Flush,
  input  logic          InValid,
  output logic          InReady,
  input  logic [31:0]   InPC,
  input  logic [31:0]   InInstr,
  output logic          OutValid,
  input  logic          OutReady,
  output logic [31:0]   OutPC,
  output logic [31:0]   OutInstr,
  output logic [1:0]    OutCtrl,
  output logic [AW:0]   Count
);

  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  // Handshake: a transfer happens on a side only in a cycle where valid and ready are
  // both high at the clock edge; valid never waits for ready, and InReady looks only at
  // the occupancy so it is free of any path from OutReady.

  logic [AW-1:0] rp, wp;
  logic [AW:0]   count;
  fq_entry_t     mem [DEPTH];
  logic [1:0]    wr_ctrl;
  logic          stored_valid;
  logic          bypass_act;
  logic          byp_take;
  logic          push, pop;

  fetchq_predecode u_pd_wr (.instr(InInstr), .ctrl(wr_ctrl));

  assign stored_valid = (count != '0);
  assign InReady      = (count != FULL_CNT);
  assign Count        = count;

`ifdef FETCHQ_BYPASS_EN
  logic [1:0] byp_ctrl;

  fetchq_predecode u_pd_byp (.instr(InInstr), .ctrl(byp_ctrl));

  assign bypass_act = ~stored_valid & InValid & ~Flush;
  // A forwarded word that decode takes right away never occupies a slot.
  assign byp_take   = bypass_act & OutReady;
`else
  assign bypass_act = 1'b0;
  assign byp_take   = 1'b0;
`endif

  assign push = InValid & InReady & ~Flush & ~byp_take;
  assign pop  = stored_valid & OutReady & ~Flush;

  assign OutValid = stored_valid | bypass_act;

  always_comb begin
    OutPC    = '0;
    OutInstr = '0;
    OutCtrl  = CTRL_SEQ;
    if (stored_valid) begin
      OutPC    = mem[rp].pc;
      OutInstr = mem[rp].instr;
      OutCtrl  = mem[rp].ctrl;
    end
`ifdef FETCHQ_BYPASS_EN
    else if (bypass_act) begin
      OutPC    = InPC;
      OutInstr = InInstr;
      OutCtrl  = byp_ctrl;
    end
`endif
  end

  always_ff @(posedge Clk) begin
    if (Reset || Flush) begin
      rp    <= '0;
      wp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + PTR_ONE;
      if (pop)  rp <= rp + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage is not cleared by reset; only the pointers and occupancy matter.
  always_ff @(posedge Clk) begin
    if (push && !Reset) begin
      mem[wp] <= '{pc: InPC, instr: InInstr, ctrl: wr_ctrl};
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a vector table for ordering, back-pressure and predecode,
// plus scoreboarded sequences for flush, pointer wrap, reset and (with FETCHQ_BYPASS_EN) bypass.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          Clk;
  logic          Reset;
  logic          Flush;
  logic          InValid;
  logic          InReady;
  logic [31:0]   InPC;
  logic [31:0]   InInstr;
  logic          OutValid;
  logic          OutReady;
  logic [31:0]   OutPC;
  logic [31:0]   OutInstr;
  logic [1:0]    OutCtrl;
  logic [AW:0]   Count;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_q[$];  // {instr, pc} of entries expected in the queue, head first

  typedef struct {
    logic        iv;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        ordy;
    logic [2:0]  e_cnt;
    logic        e_ov;
    logic        e_ir;
    logic [31:0] e_pc;
    logic [1:0]  e_ctrl;
  } vec_t;

  vec_t vecs[$];

  fetch_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Flush    (Flush),
    .InValid  (InValid),
    .InReady  (InReady),
    .InPC     (InPC),
    .InInstr  (InInstr),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .OutPC    (OutPC),
    .OutInstr (OutInstr),
    .OutCtrl  (OutCtrl),
    .Count    (Count)
  );

  // clock
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    InValid  = 1'b0;
    InPC     = '0;
    InInstr  = '0;
    OutReady = 1'b0;
    Flush    = 1'b0;
  endtask

  task automatic add_vec(input logic iv, input logic [31:0] pc, input logic [31:0] instr,
                         input logic ordy, input logic [2:0] e_cnt, input logic e_ov,
                         input logic e_ir, input logic [31:0] e_pc, input logic [1:0] e_ctrl);
    vec_t v;
    v.iv = iv; v.pc = pc; v.instr = instr; v.ordy = ordy;
    v.e_cnt = e_cnt; v.e_ov = e_ov; v.e_ir = e_ir; v.e_pc = e_pc; v.e_ctrl = e_ctrl;
    vecs.push_back(v);
  endtask

  // One clock of stimulus with the scoreboard tracking what the queue must hold afterwards.
  task automatic sb_cycle(input logic iv, input logic [31:0] pc, input logic [31:0] instr,
                          input logic ordy, input logic fl, input string name);
    bit accept, consume;
    accept  = iv && !fl && (exp_q.size() != DEPTH);
    consume = ordy && !fl && (exp_q.size() != 0);
    InValid = iv; InPC = pc; InInstr = instr; OutReady = ordy; Flush = fl;
    @(posedge Clk);
    #1;
    drive_idle();
    if (fl) begin
      exp_q.delete();
    end else begin
      if (consume) void'(exp_q.pop_front());
      if (accept)  exp_q.push_back({instr, pc});
    end
    #1;
    check({name, " count"}, 64'(Count), 64'(exp_q.size()));
    check({name, " out_valid"}, 64'(OutValid), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check({name, " out_pc"}, 64'(OutPC), 64'(exp_q[0][31:0]));
      check({name, " out_instr"}, 64'(OutInstr), 64'(exp_q[0][63:32]));
    end else begin
      check({name, " out_pc idle"}, 64'(OutPC), 64'd0);
    end
  endtask

  initial begin
    drive_idle();

    // reset
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;
    #1;
    check("reset count", 64'(Count), 64'd0);
    check("reset out_valid", 64'(OutValid), 64'd0);
    check("reset in_ready", 64'(InReady), 64'd1);
    check("reset out_pc", 64'(OutPC), 64'd0);
    check("reset out_instr", 64'(OutInstr), 64'd0);
    check("reset out_ctrl", 64'(OutCtrl), 64'd0);

    // in-order delivery with decode stalled, then drained
    add_vec(1, 32'h3000, 32'h0c000000, 0, 3'd1, 1, 1, 32'h3000, 2'b10);
    add_vec(1, 32'h3004, 32'h10000003, 0, 3'd2, 1, 1, 32'h3000, 2'b10);
    add_vec(1, 32'h3008, 32'h08000c00, 0, 3'd3, 1, 1, 32'h3000, 2'b10);
    add_vec(0, 32'h0,    32'h0,        1, 3'd2, 1, 1, 32'h3004, 2'b01);
    add_vec(0, 32'h0,    32'h0,        1, 3'd1, 1, 1, 32'h3008, 2'b10);
    add_vec(0, 32'h0,    32'h0,        1, 3'd0, 0, 1, 32'h0,    2'b00);
    // fill to full; a push alongside a pop at full is rejected
    add_vec(1, 32'h4000, 32'h0, 0, 3'd1, 1, 1, 32'h4000, 2'b00);
    add_vec(1, 32'h4004, 32'h0, 0, 3'd2, 1, 1, 32'h4000, 2'b00);
    add_vec(1, 32'h4008, 32'h0, 0, 3'd3, 1, 1, 32'h4000, 2'b00);
    add_vec(1, 32'h400c, 32'h0, 0, 3'd4, 1, 0, 32'h4000, 2'b00);
    add_vec(1, 32'h4010, 32'h0, 1, 3'd3, 1, 1, 32'h4004, 2'b00);
    add_vec(1, 32'h4010, 32'h0, 0, 3'd4, 1, 0, 32'h4004, 2'b00);
    add_vec(0, 32'h0,    32'h0, 1, 3'd3, 1, 1, 32'h4008, 2'b00);
    add_vec(0, 32'h0,    32'h0, 1, 3'd2, 1, 1, 32'h400c, 2'b00);
    add_vec(0, 32'h0,    32'h0, 1, 3'd1, 1, 1, 32'h4010, 2'b00);
    add_vec(0, 32'h0,    32'h0, 1, 3'd0, 0, 1, 32'h0,    2'b00);
    // predecode classes: beq, j, jr, seq
    add_vec(1, 32'h5000, 32'h10000003, 0, 3'd1, 1, 1, 32'h5000, 2'b01);
    add_vec(1, 32'h5004, 32'h08000c00, 0, 3'd2, 1, 1, 32'h5000, 2'b01);
    add_vec(1, 32'h5008, 32'h03e00008, 0, 3'd3, 1, 1, 32'h5000, 2'b01);
    add_vec(1, 32'h500c, 32'h00000000, 0, 3'd4, 1, 0, 32'h5000, 2'b01);
    add_vec(0, 32'h0,    32'h0,        1, 3'd3, 1, 1, 32'h5004, 2'b10);
    add_vec(0, 32'h0,    32'h0,        1, 3'd2, 1, 1, 32'h5008, 2'b11);
    add_vec(0, 32'h0,    32'h0,        1, 3'd1, 1, 1, 32'h500c, 2'b00);
    add_vec(0, 32'h0,    32'h0,        1, 3'd0, 0, 1, 32'h0,    2'b00);

    foreach (vecs[i]) begin
      InValid = vecs[i].iv; InPC = vecs[i].pc; InInstr = vecs[i].instr;
      OutReady = vecs[i].ordy; Flush = 1'b0;
      @(posedge Clk);
      #1;
      drive_idle();
      #1;
      check($sformatf("vec%0d count", i), 64'(Count), 64'(vecs[i].e_cnt));
      check($sformatf("vec%0d out_valid", i), 64'(OutValid), 64'(vecs[i].e_ov));
      check($sformatf("vec%0d in_ready", i), 64'(InReady), 64'(vecs[i].e_ir));
      check($sformatf("vec%0d out_pc", i), 64'(OutPC), 64'(vecs[i].e_pc));
      check($sformatf("vec%0d out_ctrl", i), 64'(OutCtrl), 64'(vecs[i].e_ctrl));
    end

    // flush with two entries held: offered word is dropped, pointers restart
    sb_cycle(1, 32'h6000, 32'h00000020, 0, 0, "flush fill0");
    sb_cycle(1, 32'h6004, 32'h00000021, 0, 0, "flush fill1");
    sb_cycle(1, 32'h6008, 32'h00000022, 1, 1, "flush");
    sb_cycle(1, 32'h600c, 32'h00000023, 0, 0, "post-flush push");
    sb_cycle(0, 32'h0, 32'h0, 1, 0, "post-flush drain");

    // back-to-back push/pop at one entry; pointers wrap several times
    sb_cycle(1, 32'h7000, 32'($urandom_range(0, 32'h03ffffff)), 0, 0, "wrap prime");
    for (int i = 0; i < 10; i++) begin
      sb_cycle(1, 32'h7004 + 32'(4 * i), 32'($urandom_range(0, 32'h03ffffff)), 1, 0,
               $sformatf("wrap%0d", i));
    end
    sb_cycle(0, 32'h0, 32'h0, 1, 0, "wrap drain");

    // reset mid-stream with three entries
    sb_cycle(1, 32'h9000, 32'h1, 0, 0, "rst fill0");
    sb_cycle(1, 32'h9004, 32'h2, 0, 0, "rst fill1");
    sb_cycle(1, 32'h9008, 32'h3, 0, 0, "rst fill2");
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    exp_q.delete();
    #1;
    check("mid reset count", 64'(Count), 64'd0);
    check("mid reset in_ready", 64'(InReady), 64'd1);
    check("mid reset out_valid", 64'(OutValid), 64'd0);

`ifdef FETCHQ_BYPASS_EN
    InValid = 1'b1; InPC = 32'h8000; InInstr = 32'h10000003; OutReady = 1'b1;
    #1;
    check("bypass out_valid", 64'(OutValid), 64'd1);
    check("bypass out_pc", 64'(OutPC), 64'h8000);
    check("bypass out_ctrl", 64'(OutCtrl), 64'd1);
    @(posedge Clk);
    #1;
    drive_idle();
    #1;
    check("bypass count", 64'(Count), 64'd0);
    check("bypass out_valid after", 64'(OutValid), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
